apb4_master: RTL and testbench

APB4_MASTER -- requirements
Module: apb4_master

---
 rtl/apb4_master.sv | 137 +++++++++++++
 tb/tb_apb4_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_master.sv
// rtl/apb4_master.sv - APB4 requester driven by a command/response handshake; optional wait timeout via APB4_MASTER_TIMEOUT_EN
module apb4_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_write_i,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
   input  logic [2:0]              cmd_prot_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    rsp_timeout_o,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic [2:0]              pprot,
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic                    pready,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pslverr
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   done;
   logic   timeout_hit;

   assign accept = cmd_valid_i && cmd_ready_o;
   assign done   = (state == ACCESS) && pready;

`ifdef APB4_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             rsp_timeout_q;

   // The last tolerated unanswered ACCESS cycle aborts the transfer
   assign timeout_hit   = (state == ACCESS) && !pready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign rsp_timeout_o = rsp_timeout_q;

   // Count unanswered ACCESS cycles and remember whether the response came from an abort
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         wait_cnt      <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         if (accept) begin
            wait_cnt <= '0;
         end else if ((state == ACCESS) && !pready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
         if (done) begin
            rsp_timeout_q <= 1'b0;
         end else if (timeout_hit) begin
            rsp_timeout_q <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_hit        = 1'b0;
   assign rsp_timeout_o      = 1'b0;
`endif

   // State register
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (done || timeout_hit) state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Phase outputs decoded from the current state; ready is held low during reset
   always_comb begin
      cmd_ready_o = presetn && (state == IDLE);
      psel        = (state == SETUP) || (state == ACCESS);
      penable     = (state == ACCESS);
      rsp_valid_o = (state == RESP);
   end

   // Request fields latched on accept, response fields latched when ACCESS ends
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         paddr       <= '0;
         pprot       <= '0;
         pwrite      <= 1'b0;
         pwdata      <= '0;
         pstrb       <= '0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         if (accept) begin
            paddr  <= cmd_addr_i;
            pprot  <= cmd_prot_i;
            pwrite <= cmd_write_i;
            pwdata <= cmd_wdata_i;
            pstrb  <= cmd_write_i ? cmd_strb_i : '0;
         end
         if (done) begin
            rsp_rdata_o <= pwrite ? '0 : prdata;
            rsp_err_o   <= pslverr;
         end else if (timeout_hit) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb4_master.sv
// tb/tb_apb4_master.sv - directed and randomized bench for apb4_master
module tb_apb4_master;

   localparam int TMO = 4;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_write_i;
   logic [31:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic [3:0]  cmd_strb_i;
   logic [2:0]  cmd_prot_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;
   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   int total = 0;
   int bad   = 0;

   apb4_master #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .pclk         (pclk),
      .presetn      (presetn),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_write_i  (cmd_write_i),
      .cmd_addr_i   (cmd_addr_i),
      .cmd_wdata_i  (cmd_wdata_i),
      .cmd_strb_i   (cmd_strb_i),
      .cmd_prot_i   (cmd_prot_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o),
      .rsp_timeout_o(rsp_timeout_o),
      .paddr        (paddr),
      .pprot        (pprot),
      .psel         (psel),
      .penable      (penable),
      .pwrite       (pwrite),
      .pwdata       (pwdata),
      .pstrb        (pstrb),
      .pready       (pready),
      .prdata       (prdata),
      .pslverr      (pslverr)
   );

   always #5 pclk = ~pclk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_req(input string ph, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
      chk({ph, "_paddr"}, 64'(paddr), 64'(addr));
      chk({ph, "_pwrite"}, 64'(pwrite), 64'(wr));
      chk({ph, "_pprot"}, 64'(pprot), 64'(prot));
      chk({ph, "_pstrb"}, 64'(pstrb), wr ? 64'(strb) : 64'd0);
      if (wr) chk({ph, "_pwdata"}, 64'(pwdata), 64'(wdata));
   endtask

   task automatic chk_all_zero(input string ph);
      chk({ph, "_psel"}, 64'(psel), 64'd0);
      chk({ph, "_penable"}, 64'(penable), 64'd0);
      chk({ph, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
      chk({ph, "_cmd_ready"}, 64'(cmd_ready_o), 64'd0);
      chk({ph, "_paddr"}, 64'(paddr), 64'd0);
      chk({ph, "_pprot"}, 64'(pprot), 64'd0);
      chk({ph, "_pwrite"}, 64'(pwrite), 64'd0);
      chk({ph, "_pwdata"}, 64'(pwdata), 64'd0);
      chk({ph, "_pstrb"}, 64'(pstrb), 64'd0);
      chk({ph, "_rsp_rdata"}, 64'(rsp_rdata_o), 64'd0);
      chk({ph, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
      chk({ph, "_rsp_timeout"}, 64'(rsp_timeout_o), 64'd0);
   endtask

   // One transfer: completer answers after wait_n unready ACCESS cycles; optional reset in ACCESS cycle abort_k
   task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int wait_n,
                      input bit slverr, input logic [31:0] rdata, input int rsp_delay, input int abort_k);
      bit          tmo;
      int          n_acc;
      logic [31:0] exp_rdata;
      bit          exp_err;
      bit          last;
`ifdef APB4_MASTER_TIMEOUT_EN
      tmo   = (wait_n >= TMO);
      n_acc = tmo ? TMO : wait_n + 1;
`else
      tmo   = 1'b0;
      n_acc = wait_n + 1;
`endif
      exp_rdata = (tmo || wr) ? 32'd0 : rdata;
      exp_err   = tmo ? 1'b1 : slverr;

      @(negedge pclk);
      chk("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("idle_psel", 64'(psel), 64'd0);
      chk("idle_penable", 64'(penable), 64'd0);
      chk("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
      cmd_valid_i = 1'b1;
      cmd_write_i = wr;
      cmd_addr_i  = addr;
      cmd_wdata_i = wdata;
      cmd_strb_i  = strb;
      cmd_prot_i  = prot;
      pready      = 1'($urandom);
      rsp_ready_i = 1'($urandom);

      @(negedge pclk);
      chk("setup_psel", 64'(psel), 64'd1);
      chk("setup_penable", 64'(penable), 64'd0);
      chk("setup_cmd_ready", 64'(cmd_ready_o), 64'd0);
      chk("setup_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk_req("setup", wr, addr, wdata, strb, prot);
      cmd_valid_i = 1'($urandom);
      cmd_write_i = 1'($urandom);
      cmd_addr_i  = $urandom;
      cmd_wdata_i = $urandom;
      cmd_strb_i  = 4'($urandom);
      cmd_prot_i  = 3'($urandom);
      pready      = 1'b1;
      rsp_ready_i = 1'($urandom);

      for (int k = 1; k <= n_acc; k++) begin
         @(negedge pclk);
         chk("access_psel", 64'(psel), 64'd1);
         chk("access_penable", 64'(penable), 64'd1);
         chk("access_cmd_ready", 64'(cmd_ready_o), 64'd0);
         chk("access_rsp_valid", 64'(rsp_valid_o), 64'd0);
         chk_req("access", wr, addr, wdata, strb, prot);
         last        = (k == wait_n + 1);
         pready      = last;
         prdata      = last ? rdata : $urandom;
         pslverr     = last ? slverr : 1'($urandom);
         rsp_ready_i = 1'($urandom);
         if (k == abort_k) begin
            presetn = 1'b0;
            @(negedge pclk);
            chk_all_zero("abort");
            presetn     = 1'b1;
            cmd_valid_i = 1'b0;
            pready      = 1'b0;
            rsp_ready_i = 1'b0;
            #1;
            chk("release_cmd_ready", 64'(cmd_ready_o), 64'd1);
            return;
         end
      end

      cmd_valid_i = 1'b0;
      for (int j = 0; j <= rsp_delay; j++) begin
         @(negedge pclk);
         chk("resp_valid", 64'(rsp_valid_o), 64'd1);
         chk("resp_psel", 64'(psel), 64'd0);
         chk("resp_penable", 64'(penable), 64'd0);
         chk("resp_cmd_ready", 64'(cmd_ready_o), 64'd0);
         chk("resp_rdata", 64'(rsp_rdata_o), 64'(exp_rdata));
         chk("resp_err", 64'(rsp_err_o), 64'(exp_err));
         chk("resp_timeout", 64'(rsp_timeout_o), 64'(tmo));
         chk_req("resp", wr, addr, wdata, strb, prot);
         pready      = 1'($urandom);
         prdata      = $urandom;
         pslverr     = 1'($urandom);
         rsp_ready_i = (j == rsp_delay);
      end
   endtask

   initial begin
      presetn     = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_wdata_i = '0;
      cmd_strb_i  = '0;
      cmd_prot_i  = '0;
      rsp_ready_i = 1'b0;
      pready      = 1'b0;
      prdata      = '0;
      pslverr     = 1'b0;

      repeat (2) @(negedge pclk);
      chk_all_zero("reset");
      presetn = 1'b1;
      #1;
      chk("reset_release_cmd_ready", 64'(cmd_ready_o), 64'd1);

      // Write, zero wait states
      txn(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 32'hAAAA_5555, 0, 0);
      // Read with three unready ACCESS cycles
      txn(1'b0, 32'h0000_0008, 32'h0BAD_F00D, 4'hF, 3'd2, 3, 1'b0, 32'h1234_5678, 0, 0);
      // Read error with a slow response consumer
      txn(1'b0, 32'h0000_0010, 32'h0, 4'h3, 3'd5, 0, 1'b1, 32'hCAFE_0001, 5, 0);
`ifdef APB4_MASTER_TIMEOUT_EN
      // Completer never answers: abort after TMO cycles
      txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'd1, 20, 1'b0, 32'h5A5A_5A5A, 1, 0);
      // Answer on the last tolerated cycle completes normally
      txn(1'b0, 32'h0000_0024, 32'h0, 4'h0, 3'd1, TMO - 1, 1'b0, 32'h600D_600D, 0, 0);
      txn(1'b1, 32'h0000_0028, 32'h1111_2222, 4'h5, 3'd3, TMO, 1'b0, 32'h0, 0, 0);
`endif
      // Reset during ACCESS, then a normal transfer
      txn(1'b1, 32'h0000_0030, 32'h7777_8888, 4'hC, 3'd7, 3, 1'b0, 32'h0, 0, 2);
      txn(1'b0, 32'h0000_0034, 32'h0, 4'hF, 3'd0, 1, 1'b0, 32'h8765_4321, 0, 0);

      for (int n = 0; n < 24; n++) begin
         txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
             int'($urandom_range(0, 6)), 1'($urandom), $urandom, int'($urandom_range(0, 2)), 0);
      end

      @(negedge pclk);
      chk("final_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("final_rsp_valid", 64'(rsp_valid_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
